rng_fill_ctrl: RTL

Sequencer directly upstream of rng_ram. It drives rng_ram's we_rng / addr_rng / ack_rng control port to fill a programmable address window with fresh random words, one word per handshake. Software or a top-level controller starts a fill and receives done or timeout status. Wishbone ports A/B of rng_ram remain untouched by this block.

---
 rtl/rng_pkg.sv | 22 ++
 rtl/rng_fill_ctrl_if.sv | 15 +
 rtl/rng_fill_timer.sv | 35 +++
 rtl/rng_fill_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and constants for the rng_ram fill sequencer.
package rng_pkg;

  localparam int unsigned RNG_ADDR_W = 9;
  localparam int unsigned RNG_DEPTH  = 512;

  // Word count spans 0..RNG_DEPTH inclusive, hence one extra bit.
  typedef logic [RNG_ADDR_W:0] rngCount_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StGap,
    StDone
  } rngState_e;

  function automatic rngCount_t clampCount(rngCount_t c);
    return (c > rngCount_t'(RNG_DEPTH)) ? rngCount_t'(RNG_DEPTH) : c;
  endfunction

endpackage

// File: rtl/rng_fill_ctrl_if.sv
// Write-control port between the fill sequencer (master) and rng_ram (slave).
interface rng_fill_ctrl_if
  import rng_pkg::*;
#(
  parameter int unsigned ADDR_W = RNG_ADDR_W
) ();

  logic              we_rng_o;
  logic [ADDR_W-1:0] addr_rng_o;
  logic              ack_rng_i;

  modport master (output we_rng_o, output addr_rng_o, input ack_rng_i);
  modport slave  (input we_rng_o, input addr_rng_o, output ack_rng_i);

endinterface

// File: rtl/rng_fill_timer.sv
// Loadable down-counter; load wins over decrement, holds at zero.
module rng_fill_timer #(
  parameter int unsigned Width    = 8,
  parameter int unsigned ResetVal = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] loadVal_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] cntQ, cntD;

  always_comb begin
    cntD = cntQ;
    if (load_i) begin
      cntD = loadVal_i;
    end else if (en_i && (cntQ != '0)) begin
      cntD = cntQ - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cntQ <= Width'(ResetVal);
    end else begin
      cntQ <= cntD;
    end
  end

  assign zero_o = (cntQ == '0);

endmodule

// File: rtl/rng_fill_ctrl.sv
// Fills an address window of rng_ram with fresh random words, one per handshake.
// Optional periodic refill is enabled by defining RNG_FILL_PERIODIC_EN.
module rng_fill_ctrl
  import rng_pkg::*;
#(
  parameter int unsigned ADDR_W      = RNG_ADDR_W,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned GAP_CYCLES  = 1
`ifdef RNG_FILL_PERIODIC_EN
  , parameter int unsigned REFRESH_CYCLES = 100000
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   count_i,
`ifdef RNG_FILL_PERIODIC_EN
  input  logic              periodic_en_i,
`endif
  rng_fill_ctrl_if.master   ram,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [ADDR_W:0]   words_written_o
);

  localparam logic [ADDR_W:0] MaxCount = {1'b1, {ADDR_W{1'b0}}};
  // One timer serves both the ack timeout and the gap wait; they never overlap.
  localparam int unsigned TmrW    = $clog2(ACK_TIMEOUT + GAP_CYCLES + 1);
  localparam int unsigned GapLoad = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  rngState_e         stateQ, stateD;
  logic [ADDR_W-1:0] baseQ, baseD, addrQ, addrD;
  logic [ADDR_W:0]   countQ, countD, wordsQ, wordsD, clampedCount;
  logic              timeoutQ, timeoutD;
  logic              tmrLoad, tmrZero, tmrEn, ackSeen, startReq;
  logic [TmrW-1:0]   tmrLoadVal;

  assign clampedCount = (count_i > MaxCount) ? MaxCount : count_i;
  assign ackSeen      = ram.ack_rng_i && ((stateQ == StIssue) || (stateQ == StWaitAck));
  assign tmrEn        = (stateQ == StWaitAck) || (stateQ == StGap);

`ifdef RNG_FILL_PERIODIC_EN
  localparam int unsigned RefW = $clog2(REFRESH_CYCLES + 1);
  logic refreshZero, fillEnd;

  // Any return to idle (done, timeout, abort) restarts the refresh interval.
  assign fillEnd = (stateQ != StIdle) && (stateD == StIdle);

  rng_fill_timer #(
    .Width    (RefW),
    .ResetVal (REFRESH_CYCLES - 1)
  ) uRefreshTimer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (fillEnd),
    .loadVal_i (RefW'(REFRESH_CYCLES - 1)),
    .en_i      ((stateQ == StIdle) && periodic_en_i),
    .zero_o    (refreshZero)
  );

  assign startReq = start_i || (periodic_en_i && refreshZero);
`else
  assign startReq = start_i;
`endif

  always_comb begin
    stateD     = stateQ;
    baseD      = baseQ;
    countD     = countQ;
    wordsD     = wordsQ;
    addrD      = addrQ;
    timeoutD   = timeoutQ;
    tmrLoad    = 1'b0;
    tmrLoadVal = '0;

    if (ackSeen) begin
      wordsD = wordsQ + 1'b1;
    end

    unique case (stateQ)
      StIdle: begin
        if (startReq) begin
          baseD    = base_addr_i;
          countD   = clampedCount;
          wordsD   = '0;
          timeoutD = 1'b0;
          stateD   = (clampedCount == '0) ? StDone : StIssue;
        end
      end
      StIssue, StWaitAck: begin
        if (ackSeen) begin
          if (wordsD == countQ) begin
            stateD = StDone;
          end else if (GAP_CYCLES == 0) begin
            stateD = StIssue;
          end else begin
            stateD     = StGap;
            tmrLoad    = 1'b1;
            tmrLoadVal = TmrW'(GapLoad);
          end
        end else if (stateQ == StIssue) begin
          stateD     = StWaitAck;
          tmrLoad    = 1'b1;
          tmrLoadVal = TmrW'(ACK_TIMEOUT - 1);
        end else if (tmrZero) begin
          timeoutD = 1'b1;
          stateD   = StIdle;
        end
      end
      StGap: begin
        if (tmrZero) begin
          stateD = StIssue;
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase

    // Abort overrides everything except the ack count already taken this cycle.
    if (abort_i && (stateQ != StIdle)) begin
      stateD   = StIdle;
      timeoutD = timeoutQ;
      tmrLoad  = 1'b0;
    end

    if (stateD == StIssue) begin
      addrD = baseD + wordsD[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateQ   <= StIdle;
      baseQ    <= '0;
      countQ   <= '0;
      wordsQ   <= '0;
      addrQ    <= '0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      baseQ    <= baseD;
      countQ   <= countD;
      wordsQ   <= wordsD;
      addrQ    <= addrD;
      timeoutQ <= timeoutD;
    end
  end

  rng_fill_timer #(
    .Width    (TmrW),
    .ResetVal (0)
  ) uAckGapTimer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (tmrLoad),
    .loadVal_i (tmrLoadVal),
    .en_i      (tmrEn),
    .zero_o    (tmrZero)
  );

  assign ram.we_rng_o    = (stateQ == StIssue);
  assign ram.addr_rng_o  = addrQ;
  assign busy_o          = (stateQ != StIdle);
  assign done_o          = (stateQ == StDone);
  assign timeout_o       = timeoutQ;
  assign words_written_o = wordsQ;

endmodule
